// File: rtl/npc_ctrl_pkg.sv
// Shared control definitions for the NPC core: sequencer states, immediate
// format codes, opcodes and the ebreak encoding.
package npc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_FWAIT,
        ST_EXEC,
        ST_MREQ,
        ST_MWAIT,
        ST_WB,
        ST_HALT,
        ST_TRAP
    } state_t;

    localparam logic [2:0] EXTOP_NONE = 3'd0;
    localparam logic [2:0] EXTOP_R    = 3'd1;
    localparam logic [2:0] EXTOP_I    = 3'd2;
    localparam logic [2:0] EXTOP_S    = 3'd3;
    localparam logic [2:0] EXTOP_B    = 3'd4;
    localparam logic [2:0] EXTOP_U    = 3'd5;
    localparam logic [2:0] EXTOP_J    = 3'd6;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_STORE);
    endfunction

endpackage

// File: rtl/inst_fmt_dec.sv
// Combinational opcode decoder: immediate format select plus an illegal flag
// for any opcode that has no format.
module inst_fmt_dec
    import npc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] extop,
    output logic       illegal
);

    always_comb begin
        extop = EXTOP_NONE;
        case (opcode)
            OP_REG, OP_REG32:                                  extop = EXTOP_R;
            OP_IMM, OP_IMM32, OP_LOAD, OP_JALR, OP_SYSTEM:     extop = EXTOP_I;
            OP_STORE:                                          extop = EXTOP_S;
            OP_BRANCH:                                         extop = EXTOP_B;
            OP_LUI, OP_AUIPC:                                  extop = EXTOP_U;
            OP_JAL:                                            extop = EXTOP_J;
            default:                                           extop = EXTOP_NONE;
        endcase
        illegal = (extop == EXTOP_NONE);
    end

endmodule

// File: rtl/inst_sequencer.sv
// Multi-cycle instruction sequencer: fetch, latch and decode one instruction,
// step it through execute / memory / write-back and pulse the write enables.
module inst_sequencer
    import npc_ctrl_pkg::*;
#(
    parameter int XLEN = 64
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_i,
    output logic            ifu_req_valid,
    output logic [XLEN-1:0] ifu_req_addr,
    input  logic            ifu_req_ready,
    input  logic            ifu_rsp_valid,
    input  logic [31:0]     ifu_rsp_inst,
    input  logic            ifu_rsp_err,
    output logic            lsu_req_valid,
    input  logic            lsu_req_ready,
    input  logic            lsu_rsp_valid,
    output logic [31:0]     inst_o,
    output logic [2:0]      extop_o,
    output logic            pc_we,
    output logic            rf_we,
    output logic            halt_o,
    output logic            trap_o
);

    state_t     state;
    state_t     next_state;
    logic       started;
    logic       illegal_q;
    logic [2:0] dec_extop;
    logic       dec_illegal;
    logic       accept;
    logic       load_addr;

    inst_fmt_dec u_fmt_dec (
        .opcode  (ifu_rsp_inst[6:0]),
        .extop   (dec_extop),
        .illegal (dec_illegal)
    );

    assign accept = (state == ST_FWAIT) && ifu_rsp_valid && !ifu_rsp_err;

    // The first edge out of reset also counts as entering FETCH, so the
    // address is captured there even though the state did not change.
    assign load_addr = (next_state == ST_FETCH) && ((state != ST_FETCH) || !started);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started      <= 1'b0;
            ifu_req_addr <= '0;
            inst_o       <= '0;
            extop_o      <= EXTOP_NONE;
            illegal_q    <= 1'b0;
        end else begin
            started <= 1'b1;
            if (load_addr) begin
                ifu_req_addr <= pc_i;
            end
            if (accept) begin
                inst_o    <= ifu_rsp_inst;
                extop_o   <= dec_extop;
                illegal_q <= dec_illegal;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH: if (started && ifu_req_ready) next_state = ST_FWAIT;
            ST_FWAIT: begin
                if (ifu_rsp_valid) begin
                    next_state = ifu_rsp_err ? ST_TRAP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (illegal_q) begin
                    next_state = ST_TRAP;
                end else if (inst_o == EBREAK) begin
                    next_state = ST_HALT;
                end else if (is_mem_op(inst_o[6:0])) begin
                    next_state = ST_MREQ;
                end else begin
                    next_state = ST_WB;
                end
            end
            ST_MREQ:  if (lsu_req_ready) next_state = ST_MWAIT;
            ST_MWAIT: if (lsu_rsp_valid) next_state = ST_WB;
            ST_WB:    next_state = ST_FETCH;
            ST_HALT:  next_state = ST_HALT;
            ST_TRAP:  next_state = ST_TRAP;
            default:  next_state = ST_FETCH;
        endcase
    end

    always_comb begin
        ifu_req_valid = (state == ST_FETCH) && started;
        lsu_req_valid = (state == ST_MREQ);
        pc_we         = (state == ST_WB);
        rf_we         = (state == ST_WB) && (extop_o != EXTOP_S) && (extop_o != EXTOP_B);
        halt_o        = (state == ST_HALT);
        trap_o        = (state == ST_TRAP);
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: directed and randomized instructions
// with random handshake delays, checked against a table-driven reference.
module tb_inst_sequencer;

    localparam int XLEN = 64;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] pc_i = '0;
    logic            ifu_req_valid;
    logic [XLEN-1:0] ifu_req_addr;
    logic            ifu_req_ready = 1'b0;
    logic            ifu_rsp_valid = 1'b0;
    logic [31:0]     ifu_rsp_inst = '0;
    logic            ifu_rsp_err = 1'b0;
    logic            lsu_req_valid;
    logic            lsu_req_ready = 1'b0;
    logic            lsu_rsp_valid = 1'b0;
    logic [31:0]     inst_o;
    logic [2:0]      extop_o;
    logic            pc_we;
    logic            rf_we;
    logic            halt_o;
    logic            trap_o;

    int          assertCount = 0;
    int          failCount = 0;
    logic [2:0]  fmtTable [128];
    logic [6:0]  legalOps [12];
    logic [63:0] expAddr;
    logic [31:0] lastInst;
    logic [2:0]  lastExtop;

    inst_sequencer #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_i          (pc_i),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_inst  (ifu_rsp_inst),
        .ifu_rsp_err   (ifu_rsp_err),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .inst_o        (inst_o),
        .extop_o       (extop_o),
        .pc_we         (pc_we),
        .rf_we         (rf_we),
        .halt_o        (halt_o),
        .trap_o        (trap_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, ".ifu_req_valid"}, ifu_req_valid, 0);
        checkOutput({tag, ".lsu_req_valid"}, lsu_req_valid, 0);
        checkOutput({tag, ".pc_we"}, pc_we, 0);
        checkOutput({tag, ".rf_we"}, rf_we, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkQuiet(tag);
        checkOutput({tag, ".addr"}, ifu_req_addr, 0);
        checkOutput({tag, ".inst"}, inst_o, 0);
        checkOutput({tag, ".extop"}, extop_o, 0);
        checkOutput({tag, ".halt"}, halt_o, 0);
        checkOutput({tag, ".trap"}, trap_o, 0);
    endtask

    task automatic doReset(input logic [63:0] pc);
        rst_n = 1'b0;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_err = 1'b0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
        pc_i = pc;
        expAddr = pc;
        @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        lastInst = '0;
        lastExtop = '0;
    endtask

    // Runs one instruction from its FETCH cycle to the next FETCH cycle
    // (or into a terminal state), driving every handshake in lockstep.
    task automatic applyStimulus(input logic [31:0] inst, input logic err,
                                 input int readyDelay, input int rspDelay,
                                 input int lsuReadyDelay, input int lsuRspDelay);
        logic [2:0] expExtop;
        bit         illegal;
        bit         isEbreak;
        bit         isMem;
        bit         rfExp;
        expExtop = fmtTable[inst[6:0]];
        illegal  = (expExtop == 3'd0);
        isEbreak = (inst == EBREAK_INST);
        isMem    = (inst[6:0] == 7'h03) || (inst[6:0] == 7'h23);
        rfExp    = !((expExtop == 3'd3) || (expExtop == 3'd4));

        for (int i = 0; i < readyDelay; i++) begin
            checkOutput("fetch.valid", ifu_req_valid, 1);
            checkOutput("fetch.addr", ifu_req_addr, expAddr);
            pc_i = {$urandom(), $urandom()};
            @(negedge clk);
        end
        checkOutput("fetch.valid", ifu_req_valid, 1);
        checkOutput("fetch.addr", ifu_req_addr, expAddr);
        checkOutput("fetch.pc_we", pc_we, 0);
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;

        checkOutput("fwait.valid", ifu_req_valid, 0);
        for (int i = 0; i < rspDelay; i++) begin
            checkOutput("fwait.inst", inst_o, lastInst);
            @(negedge clk);
        end
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = inst;
        ifu_rsp_err   = err;
        @(negedge clk);
        ifu_rsp_valid = 1'b0;
        ifu_rsp_err   = 1'b0;
        ifu_rsp_inst  = $urandom();

        if (err) begin
            checkOutput("err.trap", trap_o, 1);
            checkOutput("err.inst", inst_o, lastInst);
            for (int i = 0; i < 4; i++) begin
                checkQuiet("err.quiet");
                checkOutput("err.sticky", trap_o, 1);
                @(negedge clk);
            end
            return;
        end

        checkOutput("exec.inst", inst_o, inst);
        checkOutput("exec.extop", extop_o, expExtop);
        checkOutput("exec.pc_we", pc_we, 0);
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = ~inst;
        @(negedge clk);
        ifu_rsp_valid = 1'b0;

        if (illegal || isEbreak) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("term.halt", halt_o, isEbreak);
                checkOutput("term.trap", trap_o, illegal);
                checkQuiet("term.quiet");
                @(negedge clk);
            end
            return;
        end

        if (isMem) begin
            for (int i = 0; i < lsuReadyDelay; i++) begin
                checkOutput("mreq.valid", lsu_req_valid, 1);
                @(negedge clk);
            end
            checkOutput("mreq.valid", lsu_req_valid, 1);
            lsu_req_ready = 1'b1;
            @(negedge clk);
            lsu_req_ready = 1'b0;
            checkOutput("mwait.valid", lsu_req_valid, 0);
            for (int i = 0; i < lsuRspDelay; i++) begin
                checkOutput("mwait.pc_we", pc_we, 0);
                @(negedge clk);
            end
            lsu_rsp_valid = 1'b1;
            @(negedge clk);
            lsu_rsp_valid = 1'b0;
        end

        checkOutput("wb.pc_we", pc_we, 1);
        checkOutput("wb.rf_we", rf_we, rfExp);
        checkOutput("wb.inst", inst_o, inst);
        checkOutput("wb.extop", extop_o, expExtop);
        lastInst  = inst;
        lastExtop = expExtop;
        expAddr   = ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()} : expAddr + 64'd4;
        pc_i      = expAddr;
        @(negedge clk);
        checkOutput("next.pc_we", pc_we, 0);
        checkOutput("next.rf_we", rf_we, 0);
    endtask

    // Drives a load into MWAIT, then resets with a stale data response pending.
    task automatic resetInMwait();
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'h0000_2083;
        @(negedge clk);
        ifu_rsp_valid = 1'b0;
        @(negedge clk);
        lsu_req_ready = 1'b1;
        @(negedge clk);
        lsu_req_ready = 1'b0;
        checkOutput("rstmw.lsu_req_valid", lsu_req_valid, 0);
        #1 rst_n = 1'b0;
        #1 checkAllZero("rstmw");
        lsu_rsp_valid = 1'b1;
        expAddr = 64'h0000_0000_9000_0000;
        pc_i = expAddr;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstmw.pc_we", pc_we, 0);
        checkOutput("rstmw.refetch", ifu_req_valid, 1);
        lsu_rsp_valid = 1'b0;
        lastInst  = '0;
        lastExtop = '0;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] inst;

        for (int i = 0; i < 128; i++) fmtTable[i] = 3'd0;
        legalOps = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        fmtTable[7'h33] = 3'd1; fmtTable[7'h3B] = 3'd1;
        fmtTable[7'h13] = 3'd2; fmtTable[7'h1B] = 3'd2; fmtTable[7'h03] = 3'd2;
        fmtTable[7'h67] = 3'd2; fmtTable[7'h73] = 3'd2;
        fmtTable[7'h23] = 3'd3;
        fmtTable[7'h63] = 3'd4;
        fmtTable[7'h37] = 3'd5; fmtTable[7'h17] = 3'd5;
        fmtTable[7'h6F] = 3'd6;

        doReset(64'h0000_0000_8000_0000);
        applyStimulus(32'h0010_0093, 1'b0, 0, 0, 0, 0);
        applyStimulus(32'h0020_A023, 1'b0, 0, 0, 3, 0);
        applyStimulus(32'h0010_0093, 1'b0, 5, 2, 0, 0);
        applyStimulus(32'h0000_0063, 1'b0, 0, 0, 0, 0);
        applyStimulus(32'h0000_006F, 1'b0, 0, 0, 0, 0);
        applyStimulus(32'h0000_2083, 1'b0, 1, 1, 2, 3);
        applyStimulus(32'h3020_0073, 1'b0, 0, 0, 0, 0);
        applyStimulus(32'h1234_50B7, 1'b0, 0, 1, 0, 0);
        applyStimulus(32'h0000_0097, 1'b0, 2, 0, 0, 0);
        applyStimulus(32'h0020_80BB, 1'b0, 0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom();
            inst = {r[31:7], legalOps[$urandom_range(0, 11)]};
            if (inst == EBREAK_INST) inst = inst ^ 32'h8000_0000;
            applyStimulus(inst, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3));
        end

        resetInMwait();
        applyStimulus(32'h0010_0093, 1'b0, 0, 0, 0, 0);
        applyStimulus(EBREAK_INST, 1'b0, 0, 0, 0, 0);

        doReset(64'h0000_0000_8000_0100);
        applyStimulus(32'hFFFF_FFFF, 1'b0, 0, 0, 0, 0);

        doReset(64'h0000_0000_8000_0200);
        applyStimulus(32'h0010_0093, 1'b1, 1, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/inst_sequencer.md
# inst_sequencer

Multi-cycle control FSM for the NPC core: fetches one instruction at a time over a valid/ready instruction port, latches it, and decodes the immediate format select (`extop_o`) for the immediate generator. It steps each instruction through execute, an optional memory access, and write-back, then pulses the PC and register-file write enables. It sits between the instruction/data memory ports and the single-cycle datapath, turning it into a stallable multi-cycle machine.

## Interface
- `XLEN`, 64, PC/address width
- `clk`  in  1  clock, all state updated on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `pc_i`  in  XLEN  current PC from datapath
- `ifu_req_valid`  out  1  instruction fetch request
- `ifu_req_addr`  out  XLEN  fetch address (= `pc_i` captured at request start)
- `ifu_req_ready`  in  1  fetch request accepted
- `ifu_rsp_valid`  in  1  instruction returned
- `ifu_rsp_inst`  in  32  returned instruction
- `ifu_rsp_err`  in  1  fetch bus error, qualified by `ifu_rsp_valid`
- `lsu_req_valid`  out  1  data access request (loads/stores only)
- `lsu_req_ready`  in  1  data request accepted
- `lsu_rsp_valid`  in  1  data access complete
- `inst_o`  out  32  latched instruction to datapath
- `extop_o`  out  3  immediate format: 0 none, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J
- `pc_we`  out  1  one-cycle PC update pulse
- `rf_we`  out  1  one-cycle register-file write pulse
- `halt_o`  out  1  sticky, ebreak retired
- `trap_o`  out  1  sticky, illegal opcode or fetch error

## Operation
- States: FETCH, FWAIT, EXEC, MREQ, MWAIT, WB, HALT, TRAP.
- FETCH: `ifu_req_valid`=1, `ifu_req_addr` registered from `pc_i` on entry. Valid and address held stable until `ifu_req_ready`. On handshake go to FWAIT.
- FWAIT: on `ifu_rsp_valid`:
  - if `ifu_rsp_err`, go to TRAP;
  - else latch `ifu_rsp_inst` into `inst_o` and `extop_o`, then go to EXEC.
  - A response arriving in any other state is ignored.
- Opcode to extop:
  - 0110011, 0111011 → 1
  - 0010011, 0011011, 0000011, 1100111, 1110011 → 2
  - 0100011 → 3
  - 1100011 → 4
  - 0110111, 0010111 → 5
  - 1101111 → 6
  - anything else → 0, and the instruction is illegal.
- EXEC (1 cycle):
  - illegal goes to TRAP;
  - inst == 32'h0010_0073 (ebreak) goes to HALT;
  - opcode 0000011 or 0100011 goes to MREQ;
  - else goes to WB.
- MREQ: `lsu_req_valid`=1 until `lsu_req_ready`, then go to MWAIT. MWAIT: wait for `lsu_rsp_valid`, then go to WB.
- WB (1 cycle):
  - `pc_we`=1.
  - `rf_we`=1 unless extop is 3 (S) or 4 (B). rd==x0 is filtered by the register file, not here.
  - Next state is FETCH.
- HALT: sets `halt_o`. TRAP: sets `trap_o`. Both are terminal; only reset leaves them. No requests are issued and no enables asserted in either.

## Timing
- Reset values:
  - state FETCH, all outputs 0.
  - `ifu_req_addr` 0; it is reloaded from `pc_i` on the first clock edge after deassertion, and `ifu_req_valid` rises that same cycle.
- Responses arrive no earlier than the cycle after the request handshake. `ready` may already be high in the cycle valid rises, which gives a one-cycle handshake.
- Best-case latency:
  - ALU/branch/jump instruction: 4 cycles (FETCH, FWAIT, EXEC, WB).
  - Load/store: 6 cycles.
- `inst_o`/`extop_o` change only on the FWAIT accept edge. They stay stable through EXEC, MREQ, MWAIT and WB.
- `pc_we`/`rf_we` are high exactly one cycle per retired instruction and never outside WB.
- Reset asserted mid-transaction clears all state immediately. Any in-flight response after reset release is ignored until the next FETCH handshake.
- The ebreak check uses the full 32-bit compare; other 1110011 encodings retire normally as I-type.

## Structure
- Shared package `npc_ctrl_pkg` holds:
  - state enum;
  - EXTOP_NONE/R/I/S/B/U/J constants (0–6), shared with the immediate generator;
  - opcode localparams;
  - EBREAK constant.
- One sub-module, `inst_fmt_dec`, is combinational: opcode[6:0] in, extop[2:0] and illegal out. It is reused by the later pipelined decode stage.

## Test plan
- Reset, then `pc_i`=0x8000_0000, ready=1, response 0x0010_0093 (addi) one cycle later → `ifu_req_addr`=0x8000_0000, `extop_o`=2, `pc_we`=`rf_we`=1 in cycle 4, new FETCH in cycle 5.
- sw 0x0020_A023 with `lsu_req_ready` delayed 3 cycles → `lsu_req_valid` held 4 cycles, `extop_o`=3, `rf_we`=0, `pc_we` pulses once.
- Fetch with `ifu_req_ready` low for 5 cycles while `pc_i` changes → `ifu_req_addr` stays at the value captured on FETCH entry, `ifu_req_valid` never drops.
- Instructions 0x0000_0063 (beq) then 0x0000_006F (jal) → `extop_o` 4 then 6; `rf_we` 0 then 1.
- ebreak 0x0010_0073 → `halt_o`=1 from EXEC+1, no further `ifu_req_valid`. Illegal 0xFFFF_FFFF, or `ifu_rsp_err`=1 → `trap_o`=1, no `pc_we`.
- `rst_n` low during MWAIT → all outputs 0 immediately. After release, a fresh fetch occurs and the stale `lsu_rsp_valid` produces no `pc_we`.
